// File: rtl/shot_judge_pkg.sv
// Shared game definitions for the shot launcher/judge: FSM encoding and
// coordinate/shot defaults.
package shot_judge_pkg;

  localparam int unsigned CoordW       = 5;
  localparam int unsigned ShotsDefault = 5;

  typedef enum logic [1:0] {
    StReady,
    StFlight,
    StJudge,
    StDone
  } state_e;

endpackage

// File: rtl/abs_diff5.sv
// Combinational 5-bit unsigned absolute difference |a - b| (no wrap-around).
module abs_diff5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] diff
);

  assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/shot_judge.sv
// Ball launcher and hit/miss judge: fires from the aim column, advances one row
// per tick, judges against the target latched at launch, and keeps score.
module shot_judge
  import shot_judge_pkg::*;
#(
  parameter int unsigned HIT_TOL = 1,
  parameter int unsigned SHOTS   = ShotsDefault,
  parameter int unsigned SCORE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                start_new_game,
  input  logic                tick,
  input  logic                fire,
  input  logic [CoordW-1:0]   aim_x,
  input  logic [CoordW-1:0]   target_x,
  input  logic [CoordW-1:0]   target_y,
  output logic [CoordW-1:0]   ball_x,
  output logic [CoordW-1:0]   ball_y,
  output logic                ball_active,
  output logic                result_valid,
  output logic                result_hit,
  output logic [SCORE_W-1:0]  score,
  output logic [3:0]          shots_left,
  output logic                game_over
);

  localparam logic [CoordW-1:0]  HitTol    = 5'(HIT_TOL);
  localparam logic [3:0]         ShotsInit = 4'(SHOTS);
  localparam logic [SCORE_W-1:0] ScoreMax  = '1;

  state_e             state_q, state_d;
  logic [CoordW-1:0]  ball_x_q, ball_x_d;
  logic [CoordW-1:0]  ball_y_q, ball_y_d;
  logic [CoordW-1:0]  tgt_x_q, tgt_x_d;
  logic [CoordW-1:0]  tgt_y_q, tgt_y_d;
  logic               result_valid_q, result_valid_d;
  logic               result_hit_q, result_hit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         shots_q, shots_d;

  logic [CoordW-1:0]  miss_dist;
  logic               hit;

  abs_diff5 u_abs_diff5 (
    .a    (ball_x_q),
    .b    (tgt_x_q),
    .diff (miss_dist)
  );

  assign hit = (miss_dist <= HitTol);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StReady;
      ball_x_q       <= '0;
      ball_y_q       <= '0;
      tgt_x_q        <= '0;
      tgt_y_q        <= '0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      score_q        <= '0;
      shots_q        <= ShotsInit;
    end else begin
      state_q        <= state_d;
      ball_x_q       <= ball_x_d;
      ball_y_q       <= ball_y_d;
      tgt_x_q        <= tgt_x_d;
      tgt_y_q        <= tgt_y_d;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      score_q        <= score_d;
      shots_q        <= shots_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ball_x_d       = ball_x_q;
    ball_y_d       = ball_y_q;
    tgt_x_d        = tgt_x_q;
    tgt_y_d        = tgt_y_q;
    result_valid_d = result_valid_q;
    result_hit_d   = result_hit_q;
    score_d        = score_q;
    shots_d        = shots_q;

    if (ena) begin
      // The pulse is cleared on the next enabled cycle, so it never spans two.
      result_valid_d = 1'b0;
      if (start_new_game) begin
        // Abort without a result; result_hit keeps the last judgement.
        state_d  = StReady;
        ball_x_d = '0;
        ball_y_d = '0;
        tgt_x_d  = '0;
        tgt_y_d  = '0;
        score_d  = '0;
        shots_d  = ShotsInit;
      end else begin
        unique case (state_q)
          StReady: begin
            if (fire) begin
              ball_x_d = aim_x;
              ball_y_d = '0;
              tgt_x_d  = target_x;
              tgt_y_d  = target_y;
              state_d  = StFlight;
            end
          end
          StFlight: begin
            // Arrival is checked before incrementing, so ball_y never wraps.
            if (tick) begin
              if (ball_y_q == tgt_y_q) begin
                state_d = StJudge;
              end else begin
                ball_y_d = ball_y_q + 5'd1;
              end
            end
          end
          StJudge: begin
            result_valid_d = 1'b1;
            result_hit_d   = hit;
            if (hit && (score_q != ScoreMax)) begin
              score_d = score_q + 1'b1;
            end
            shots_d = shots_q - 4'd1;
            state_d = (shots_q == 4'd1) ? StDone : StReady;
          end
          StDone: begin
          end
          default: state_d = StReady;
        endcase
      end
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign ball_active  = (state_q == StFlight);
  assign result_valid = result_valid_q;
  assign result_hit   = result_hit_q;
  assign score        = score_q;
  assign shots_left   = shots_q;
  assign game_over    = (state_q == StDone);

endmodule

// File: tb/tb_shot_judge.sv
// Bench for shot_judge: table-driven shots, hand-written corner sequences and
// random shots checked against a shot-level game model.
module tb_shot_judge;

  localparam int TolRef = 1;

  logic       clk = 1'b0;
  logic       reset, ena, start_new_game, tick, fire;
  logic [4:0] aim_x, target_x, target_y;

  logic [4:0] ball_x, ball_y;
  logic       ball_active, result_valid, result_hit, game_over;
  logic [7:0] score;
  logic [3:0] shots_left;

  logic [4:0] ball_x_s, ball_y_s;
  logic       ball_active_s, result_valid_s, result_hit_s, game_over_s;
  logic [1:0] score_s;
  logic [3:0] shots_left_s;

  shot_judge dut (
    .clk            (clk),
    .reset          (reset),
    .ena            (ena),
    .start_new_game (start_new_game),
    .tick           (tick),
    .fire           (fire),
    .aim_x          (aim_x),
    .target_x       (target_x),
    .target_y       (target_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .ball_active    (ball_active),
    .result_valid   (result_valid),
    .result_hit     (result_hit),
    .score          (score),
    .shots_left     (shots_left),
    .game_over      (game_over)
  );

  shot_judge #(.SCORE_W(2)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .ena            (ena),
    .start_new_game (start_new_game),
    .tick           (tick),
    .fire           (fire),
    .aim_x          (aim_x),
    .target_x       (target_x),
    .target_y       (target_y),
    .ball_x         (ball_x_s),
    .ball_y         (ball_y_s),
    .ball_active    (ball_active_s),
    .result_valid   (result_valid_s),
    .result_hit     (result_hit_s),
    .score          (score_s),
    .shots_left     (shots_left_s),
    .game_over      (game_over_s)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hits_m;
  int shots_m;
  bit last_hit_m;

  typedef struct {
    logic [4:0] aim;
    logic [4:0] tx;
    logic [4:0] ty;
    bit         exp_hit;
  } shot_vec_t;

  shot_vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit ref_hit(input int aim, input int tx);
    int d;
    d = (aim > tx) ? aim - tx : tx - aim;
    return d <= TolRef;
  endfunction

  task automatic check_game(input string tag);
    check({tag, "_score"}, score, (hits_m > 255) ? 255 : hits_m);
    check({tag, "_score_sat"}, score_s, (hits_m > 3) ? 3 : hits_m);
    check({tag, "_shots_left"}, shots_left, shots_m);
    check({tag, "_game_over"}, game_over, (shots_m == 0) ? 1 : 0);
  endtask

  task automatic new_game();
    start_new_game = 1'b1;
    step();
    start_new_game = 1'b0;
    hits_m  = 0;
    shots_m = 5;
  endtask

  // One complete shot from READY: launch, ty+1 ticks with idle gaps, judgement.
  task automatic shot(input logic [4:0] aim, input logic [4:0] tx, input logic [4:0] ty,
                      input bit exp_hit);
    aim_x    = aim;
    target_x = tx;
    target_y = ty;
    fire     = 1'b1;
    step();
    fire = 1'b0;
    check("launch_active", ball_active, 1);
    check("launch_x", ball_x, aim);
    check("launch_y", ball_y, 0);
    // Target moves after launch; judging must use the latched one.
    target_x = 5'($urandom);
    target_y = 5'($urandom);
    for (int k = 0; k < int'(ty); k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    check("arrive_y", ball_y, ty);
    check("arrive_active", ball_active, 1);
    check("rv_before_last_tick", result_valid, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("rv_early", result_valid, 0);
    check("judge_inactive", ball_active, 0);
    check("judge_y_held", ball_y, ty);
    step();
    hits_m  += exp_hit ? 1 : 0;
    shots_m -= 1;
    last_hit_m = exp_hit;
    check("rv_pulse", result_valid, 1);
    check("result_hit", result_hit, exp_hit);
    check_game("judge");
    step();
    check("rv_one_cycle", result_valid, 0);
    check("result_hit_held", result_hit, exp_hit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_seen;
    logic [4:0] a, t, y;

    vecs[0] = '{aim: 5'd13, tx: 5'd12, ty: 5'd30, exp_hit: 1'b1};
    vecs[1] = '{aim: 5'd20, tx: 5'd12, ty: 5'd31, exp_hit: 1'b0};
    vecs[2] = '{aim: 5'd0,  tx: 5'd31, ty: 5'd31, exp_hit: 1'b0};
    vecs[3] = '{aim: 5'd11, tx: 5'd12, ty: 5'd2,  exp_hit: 1'b1};
    vecs[4] = '{aim: 5'd12, tx: 5'd12, ty: 5'd0,  exp_hit: 1'b1};

    reset = 1'b1; ena = 1'b1; start_new_game = 1'b0; tick = 1'b0; fire = 1'b0;
    aim_x = '0; target_x = '0; target_y = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    hits_m = 0; shots_m = 5; last_hit_m = 1'b0;
    check_game("reset");
    check("reset_rv", result_valid, 0);
    check("reset_hit", result_hit, 0);
    check("reset_active", ball_active, 0);
    check("reset_x", ball_x, 0);
    check("reset_y", ball_y, 0);

    for (int i = 0; i < 5; i++) begin
      shot(vecs[i].aim, vecs[i].tx, vecs[i].ty, vecs[i].exp_hit);
    end

    // DONE: fire and tick have no effect; ball position holds.
    aim_x = 5'd7; fire = 1'b1;
    step();
    fire = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check_game("done");
    check("done_active", ball_active, 0);
    check("done_x_held", ball_x, 12);
    check("done_y_held", ball_y, 0);

    new_game();
    check_game("newgame");
    check("newgame_x", ball_x, 0);
    check("newgame_hit_held", result_hit, last_hit_m);

    // start_new_game beats a simultaneous fire.
    fire = 1'b1; aim_x = 5'd9;
    new_game();
    fire = 1'b0;
    check("sng_beats_fire", ball_active, 0);
    check_game("sng_fire");

    // Five hits: the 2-bit score saturates at 3.
    for (int i = 0; i < 5; i++) begin
      a = 5'($urandom);
      shot(a, a, 5'($urandom_range(0, 7)), 1'b1);
    end
    check("sat_score", score_s, 3);
    new_game();

    // Mid-flight: ena drop loses a tick, then start_new_game aborts silently.
    aim_x = 5'd5; target_x = 5'd5; target_y = 5'd20; fire = 1'b1;
    step();
    fire = 1'b0;
    repeat (10) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    check("flight_y10", ball_y, 10);
    ena = 1'b0;
    step();
    tick = 1'b1; start_new_game = 1'b0;
    step();
    tick = 1'b0;
    check("ena_low_y", ball_y, 10);
    check("ena_low_active", ball_active, 1);
    step();
    step();
    ena = 1'b1;
    check("ena_back_y", ball_y, 10);
    new_game();
    check("abort_rv", result_valid, 0);
    check("abort_active", ball_active, 0);
    check("abort_hit_held", result_hit, last_hit_m);
    check_game("abort");
    rv_seen = 0;
    repeat (40) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (result_valid) rv_seen++;
    end
    check("abort_no_result", rv_seen, 0);
    check("abort_y", ball_y, 0);

    // Random shots against the model, starting new games as they end.
    for (int i = 0; i < 14; i++) begin
      if (shots_m == 0) new_game();
      a = 5'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        t = 5'($urandom);
      end else begin
        t = 5'(int'(a) + $urandom_range(0, 4) - 2 < 0 ? 0 :
               (int'(a) + $urandom_range(0, 4) - 2 > 31 ? 31 : int'(a) + 1 - 1));
        if ($urandom_range(0, 1) == 1 && a < 5'd31) t = a + 5'd1;
      end
      y = 5'($urandom_range(0, 31));
      shot(a, t, y, ref_hit(int'(a), int'(t)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
